mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch requester (program counter side) and the data requester (load/store side).
- Lets the core move from a dual-ported memory model to a realistic single port, with the core stalling on the handshakes.
- Arbitrates between requesters, sequences each access over a fixed memory latency, and returns one response per accepted request.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Grants one requester in IDLE, holds the port for MEM_LATENCY cycles, then pulses one response.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req_valid,
   output logic                  inst_req_ready,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_resp_valid,
   output logic [DATA_WIDTH-1:0] inst_resp_data,
   input  logic                  data_req_valid,
   output logic                  data_req_ready,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [2:0]            data_bytes,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_resp_valid,
   output logic [DATA_WIDTH-1:0] data_resp_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read_en,
   output logic [2:0]            mem_bytes_to_write,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_e;

   localparam logic [2:0] LatLoad   = 3'(MEM_LATENCY);
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e                state_q, state_d;
   logic [3:0]            starve_q, starve_d;
   logic [2:0]            latCnt_q, latCnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            bytes_q, bytes_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  srcData_q, srcData_d;
   logic                  instRespValid_q, instRespValid_d;
   logic                  dataRespValid_q, dataRespValid_d;
   logic [DATA_WIDTH-1:0] instRespData_q, instRespData_d;
   logic [DATA_WIDTH-1:0] dataRespData_q, dataRespData_d;

   logic grantInst;
   logic grantData;
   logic dataIsStore;
   logic inAccess;
   logic firstAccess;

   // Only 1, 2 and 4 byte stores write; every other size code behaves as a load.
   assign dataIsStore = (data_bytes == 3'd1) || (data_bytes == 3'd2) || (data_bytes == 3'd4);

   // Data wins by default; a fetch that has lost STARVE_LIMIT times in a row takes the port.
   always_comb begin
      grantInst = 1'b0;
      grantData = 1'b0;
      if ((state_q == IDLE) && !rst) begin
         if (inst_req_valid && (!data_req_valid || (starve_q == StarveMax))) begin
            grantInst = 1'b1;
         end else if (data_req_valid) begin
            grantData = 1'b1;
         end
      end
   end

   assign inst_req_ready = grantInst;
   assign data_req_ready = grantData;

   // Next-state logic: latch the winner, count down the access, capture read data on the last cycle.
   always_comb begin
      state_d         = state_q;
      starve_d        = starve_q;
      latCnt_d        = latCnt_q;
      addr_d          = addr_q;
      bytes_d         = bytes_q;
      wdata_d         = wdata_q;
      srcData_d       = srcData_q;
      instRespValid_d = 1'b0;
      dataRespValid_d = 1'b0;
      instRespData_d  = instRespData_q;
      dataRespData_d  = dataRespData_q;

      if (grantInst) begin
         starve_d = 4'd0;
      end else if (grantData && inst_req_valid && (starve_q != StarveMax)) begin
         starve_d = starve_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (grantInst || grantData) begin
               state_d   = ACCESS;
               latCnt_d  = LatLoad;
               srcData_d = grantData;
               addr_d    = grantData ? data_addr : inst_addr;
               bytes_d   = (grantData && dataIsStore) ? data_bytes : 3'd0;
               wdata_d   = grantData ? data_wdata : '0;
            end
         end
         ACCESS: begin
            if (latCnt_q == 3'd1) begin
               state_d = IDLE;
               if (srcData_q) begin
                  dataRespValid_d = 1'b1;
                  dataRespData_d  = (bytes_q != 3'd0) ? '0 : mem_read_data;
               end else begin
                  instRespValid_d = 1'b1;
                  instRespData_d  = mem_read_data;
               end
            end else begin
               latCnt_d = latCnt_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset aborts any access in flight, so its response pulse is never issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         starve_q        <= 4'd0;
         latCnt_q        <= 3'd0;
         addr_q          <= '0;
         bytes_q         <= 3'd0;
         wdata_q         <= '0;
         srcData_q       <= 1'b0;
         instRespValid_q <= 1'b0;
         dataRespValid_q <= 1'b0;
         instRespData_q  <= '0;
         dataRespData_q  <= '0;
      end else begin
         state_q         <= state_d;
         starve_q        <= starve_d;
         latCnt_q        <= latCnt_d;
         addr_q          <= addr_d;
         bytes_q         <= bytes_d;
         wdata_q         <= wdata_d;
         srcData_q       <= srcData_d;
         instRespValid_q <= instRespValid_d;
         dataRespValid_q <= dataRespValid_d;
         instRespData_q  <= instRespData_d;
         dataRespData_q  <= dataRespData_d;
      end
   end

   // The write strobe is confined to the first access cycle so a store never repeats.
   assign inAccess           = (state_q == ACCESS);
   assign firstAccess        = inAccess && (latCnt_q == LatLoad);
   assign busy               = inAccess;
   assign mem_addr           = inAccess ? addr_q : '0;
   assign mem_read_en        = inAccess && (bytes_q == 3'd0);
   assign mem_bytes_to_write = firstAccess ? bytes_q : 3'd0;
   assign mem_write_data     = (firstAccess && (bytes_q != 3'd0)) ? wdata_q : '0;

   assign inst_resp_valid = instRespValid_q;
   assign inst_resp_data  = instRespData_q;
   assign data_resp_valid = dataRespValid_q;
   assign data_resp_data  = dataRespData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a cycle-count reference model.
// A small 8-word memory answers reads only on the last access cycle.
module tb_mem_port_arbiter;

   localparam int ML = 3;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_req_valid = 1'b0;
   logic        inst_req_ready;
   logic [31:0] inst_addr = '0;
   logic        inst_resp_valid;
   logic [31:0] inst_resp_data;
   logic        data_req_valid = 1'b0;
   logic        data_req_ready;
   logic [31:0] data_addr = '0;
   logic [2:0]  data_bytes = '0;
   logic [31:0] data_wdata = '0;
   logic        data_resp_valid;
   logic [31:0] data_resp_data;
   logic [31:0] mem_addr;
   logic        mem_read_en;
   logic [2:0]  mem_bytes_to_write;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(ML), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
      .inst_resp_valid(inst_resp_valid), .inst_resp_data(inst_resp_data),
      .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_addr(data_addr),
      .data_bytes(data_bytes), .data_wdata(data_wdata),
      .data_resp_valid(data_resp_valid), .data_resp_data(data_resp_data),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_bytes_to_write(mem_bytes_to_write),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
   );

   function automatic logic [31:0] initWord(input int i);
      return 32'hC0DE_0000 | (32'(i) * 32'h0000_1111);
   endfunction

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] n);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (b < int'(n)) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic bit isStore(input logic [2:0] n);
      return (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
   endfunction

   function automatic logic [31:0] randAddr();
      return 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
   endfunction

   // Memory: the read word is only presented on the ML-th consecutive read cycle.
   logic [31:0] memArr [8];
   logic [2:0]  rdCnt = 3'd0;
   bit          loaded = 1'b0;

   assign mem_read_data = (mem_read_en && (rdCnt == 3'(ML - 1))) ? memArr[mem_addr[4:2]] : 32'hA5A5_A5A5;

   always @(posedge clk) begin
      rdCnt <= mem_read_en ? rdCnt + 3'd1 : 3'd0;
      if (!loaded) begin
         for (int i = 0; i < 8; i++) memArr[i] <= initWord(i);
         loaded <= 1'b1;
      end else if (isStore(mem_bytes_to_write)) begin
         memArr[mem_addr[4:2]] <= mergeBytes(memArr[mem_addr[4:2]], mem_write_data, mem_bytes_to_write);
      end
   end

   int total = 0;
   int bad = 0;

   // Reference model state, expressed in absolute cycle numbers.
   int          cyc = 0;
   int          idleAt = 0;
   int          respAt = -1;
   int          wrAt = -1;
   bit          respIsInst = 1'b0;
   bit          accRead = 1'b0;
   logic [31:0] respVal = '0;
   logic [31:0] accAddr = '0;
   logic [31:0] wrData = '0;
   logic [2:0]  wrBytes = '0;
   int          starve = 0;
   logic [31:0] lastInst = '0;
   logic [31:0] lastData = '0;
   logic [31:0] shadow [8];

   bit lastIAcc = 1'b0;
   bit lastDAcc = 1'b0;
   int iRespCnt = 0;
   int dRespCnt = 0;
   int lastIRespCyc = -1;
   int lastDRespCyc = -1;
   int lastDAccCyc = -1;
   int wrCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: check every output against the model, then advance the model.
   task automatic runCycle();
      bit          idle, instWins, eIR, eDR, eIV, eDV;
      logic [2:0]  eBytes;
      logic [31:0] eWData, eAddr;
      #1;
      idle     = (cyc >= idleAt);
      instWins = inst_req_valid && (!data_req_valid || (starve >= SL));
      eIR      = idle && !rst && instWins;
      eDR      = idle && !rst && data_req_valid && !instWins;
      eIV      = (respAt == cyc) && respIsInst;
      eDV      = (respAt == cyc) && !respIsInst;
      if (eIV) lastInst = respVal;
      if (eDV) lastData = respVal;
      eBytes = (wrAt == cyc) ? wrBytes : 3'd0;
      eWData = (wrAt == cyc) ? wrData : 32'd0;
      eAddr  = idle ? 32'd0 : accAddr;

      checkOutput("inst_ready", 32'(inst_req_ready), 32'(eIR));
      checkOutput("data_ready", 32'(data_req_ready), 32'(eDR));
      checkOutput("busy", 32'(busy), 32'(!idle));
      checkOutput("read_en", 32'(mem_read_en), 32'(!idle && accRead));
      checkOutput("mem_addr", mem_addr, eAddr);
      checkOutput("wr_bytes", 32'(mem_bytes_to_write), 32'(eBytes));
      checkOutput("wr_data", mem_write_data, eWData);
      checkOutput("inst_rvalid", 32'(inst_resp_valid), 32'(eIV));
      checkOutput("inst_rdata", inst_resp_data, lastInst);
      checkOutput("data_rvalid", 32'(data_resp_valid), 32'(eDV));
      checkOutput("data_rdata", data_resp_data, lastData);

      lastIAcc = inst_req_valid && inst_req_ready;
      lastDAcc = data_req_valid && data_req_ready;
      if (lastDAcc) lastDAccCyc = cyc;
      if (inst_resp_valid === 1'b1) begin iRespCnt++; lastIRespCyc = cyc; end
      if (data_resp_valid === 1'b1) begin dRespCnt++; lastDRespCyc = cyc; end
      if (mem_bytes_to_write != 3'd0) wrCount++;

      if (rst) begin
         idleAt = cyc + 1; respAt = -1; wrAt = -1; starve = 0;
         lastInst = '0; lastData = '0;
      end else if (eIR || eDR) begin
         if (eDR && inst_req_valid) starve = (starve < SL) ? starve + 1 : SL;
         if (eIR) starve = 0;
         idleAt     = cyc + ML + 1;
         respAt     = idleAt;
         respIsInst = eIR;
         accAddr    = eIR ? inst_addr : data_addr;
         if (eDR && isStore(data_bytes)) begin
            accRead = 1'b0; respVal = '0;
            wrAt = cyc + 1; wrBytes = data_bytes; wrData = data_wdata;
            shadow[accAddr[4:2]] = mergeBytes(shadow[accAddr[4:2]], data_wdata, data_bytes);
         end else begin
            accRead = 1'b1;
            respVal = shadow[accAddr[4:2]];
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Random requesters that hold valid and payload until accepted, occasionally withdrawing.
   task automatic applyStimulus();
      if (lastIAcc || !inst_req_valid) begin
         inst_req_valid = ($urandom_range(0, 2) != 0);
         inst_addr      = randAddr();
      end else if ($urandom_range(0, 15) == 0) begin
         inst_req_valid = 1'b0;
      end
      if (lastDAcc || !data_req_valid) begin
         data_req_valid = ($urandom_range(0, 2) != 0);
         data_addr      = randAddr();
         data_bytes     = 3'($urandom_range(0, 7));
         data_wdata     = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
         data_req_valid = 1'b0;
      end
   endtask

   initial begin
      int          k, accCyc, cntBefore, wrBefore, nGrant;
      logic [9:0]  grants;
      logic [31:0] expWord;

      for (int i = 0; i < 8; i++) shadow[i] = initWord(i);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      runCycle();

      $display("[TB] single fetch");
      inst_req_valid = 1'b1; inst_addr = 32'h110;
      accCyc = cyc;
      runCycle();
      inst_req_valid = 1'b0;
      for (int i = 0; i < ML + 1; i++) runCycle();
      checkOutput("fetch_latency", 32'(lastIRespCyc - accCyc), 32'(ML + 1));
      checkOutput("fetch_data", inst_resp_data, initWord(4));

      $display("[TB] store then load");
      wrBefore = wrCount;
      data_req_valid = 1'b1; data_addr = 32'h100; data_bytes = 3'd4; data_wdata = 32'hDEAD_BEEF;
      accCyc = cyc;
      runCycle();
      data_bytes = 3'd0; data_wdata = 32'h0;
      k = 0;
      do begin runCycle(); k++; end while (!lastDAcc && k < 10);
      checkOutput("load_accepted", 32'(lastDAcc), 32'd1);
      checkOutput("load_accept_cycle", 32'(lastDAccCyc - accCyc), 32'(ML + 1));
      checkOutput("store_ack_cycle", 32'(lastDRespCyc), 32'(lastDAccCyc));
      data_req_valid = 1'b0;
      for (int i = 0; i < ML + 1; i++) runCycle();
      checkOutput("load_data", data_resp_data, 32'hDEAD_BEEF);
      checkOutput("write_count", 32'(wrCount - wrBefore), 32'd1);

      $display("[TB] starvation");
      inst_req_valid = 1'b1; inst_addr = 32'h104;
      data_req_valid = 1'b1; data_addr = 32'h108; data_bytes = 3'd0;
      nGrant = 0; grants = '0; k = 0;
      while (nGrant < 10 && k < 100) begin
         runCycle(); k++;
         if (lastIAcc || lastDAcc) begin
            grants[nGrant] = lastIAcc;
            nGrant++;
            if (lastIAcc) inst_addr = randAddr();
            if (lastDAcc) data_addr = randAddr();
         end
      end
      checkOutput("grant_count", 32'(nGrant), 32'd10);
      checkOutput("grant_order", 32'(grants), 32'b10_0001_0000);
      inst_req_valid = 1'b0; data_req_valid = 1'b0;
      for (int i = 0; i < ML + 1; i++) runCycle();

      $display("[TB] reset during store");
      cntBefore = dRespCnt;
      data_req_valid = 1'b1; data_addr = 32'h108; data_bytes = 3'd2; data_wdata = 32'h1234_ABCD;
      runCycle();
      data_req_valid = 1'b0;
      runCycle();
      rst = 1'b1;
      runCycle();
      rst = 1'b0;
      #1;
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_wr", 32'(mem_bytes_to_write), 32'd0);
      checkOutput("post_reset_addr", mem_addr, 32'd0);
      checkOutput("post_reset_rdata", data_resp_data, 32'd0);
      for (int i = 0; i < ML + 2; i++) runCycle();
      checkOutput("aborted_no_resp", 32'(dRespCnt - cntBefore), 32'd0);
      expWord = mergeBytes(initWord(2), 32'h1234_ABCD, 3'd2);
      inst_req_valid = 1'b1; inst_addr = 32'h108;
      runCycle();
      inst_req_valid = 1'b0;
      for (int i = 0; i < ML + 1; i++) runCycle();
      checkOutput("fetch_after_reset", inst_resp_data, expWord);

      $display("[TB] load with size code 6");
      wrBefore = wrCount;
      data_req_valid = 1'b1; data_addr = 32'h10C; data_bytes = 3'd6; data_wdata = 32'hFFFF_FFFF;
      runCycle();
      data_req_valid = 1'b0;
      for (int i = 0; i < ML + 1; i++) runCycle();
      checkOutput("odd_size_data", data_resp_data, initWord(3));
      checkOutput("odd_size_no_write", 32'(wrCount - wrBefore), 32'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++) begin
         applyStimulus();
         runCycle();
      end
      inst_req_valid = 1'b0; data_req_valid = 1'b0;
      for (int i = 0; i < ML + 2; i++) runCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
